// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler that shares one serial DAC among NCH requesters,
// sending a 24-bit write-and-update frame per grant and acknowledging the latch.
module dac_update_scheduler #(
   parameter int         NCH    = 4,
   parameter int         DW     = 12,
   parameter int         CLKDIV = 2,
   parameter logic [3:0] CMD    = 4'b0011,
   parameter int         GAP    = 2
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [NCH-1:0]    REQ,
   input  logic [NCH*DW-1:0] DATA,
   output logic [NCH-1:0]    ACK,
   output logic              BUSY,
   output logic              SCK,
   output logic              Dout,
   output logic              CSLD
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t         state_q, state_d;
   logic [3:0]     ptr_q, ptr_d;
   logic [3:0]     grant_q, grant_d;
   logic [23:0]    shift_q, shift_d;
   logic [4:0]     bit_q, bit_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           sck_q, sck_d;
   logic           dout_q, dout_d;
   logic           csld_q, csld_d;
   logic           busy_q, busy_d;
   logic [NCH-1:0] ack_q, ack_d;

   logic           req_any;
   logic [3:0]     pick;
   logic [3:0]     pick_next;
   logic [DW-1:0]  pick_data;
   logic [15:0]    pick_word;
   int             idx;

   // Scan downward so the last hit is the first requester at or after the pointer.
   always_comb begin
      req_any = 1'b0;
      pick    = '0;
      idx     = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = int'(ptr_q) + i;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (REQ[idx]) begin
            req_any = 1'b1;
            pick    = 4'(idx);
         end
      end
      pick_next = (pick == 4'(NCH - 1)) ? 4'd0 : pick + 4'd1;
      pick_data = DATA[pick*DW +: DW];
      pick_word = 16'(pick_data) << (16 - DW);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      sck_d   = sck_q;
      dout_d  = dout_q;
      csld_d  = csld_q;
      busy_d  = busy_q;
      ack_d   = '0;

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               state_d = ST_SHIFT;
               grant_d = pick;
               ptr_d   = pick_next;
               shift_d = {CMD, pick, pick_word};
               dout_d  = CMD[3];
               bit_d   = 5'd23;
               cnt_d   = '0;
               sck_d   = 1'b0;
               csld_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         // Dout only moves on the SCK fall so the DAC sees it stable on the rise.
         ST_SHIFT: begin
            if (cnt_q == 16'(CLKDIV - 1)) begin
               cnt_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else if (bit_q == 5'd0) begin
                  sck_d   = 1'b0;
                  csld_d  = 1'b1;
                  dout_d  = 1'b0;
                  ack_d   = NCH'(1) << grant_q;
                  state_d = ST_GAP;
               end else begin
                  sck_d   = 1'b0;
                  shift_d = shift_q << 1;
                  dout_d  = shift_q[22];
                  bit_d   = bit_q - 5'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         ST_GAP: begin
            if (cnt_q == 16'(GAP - 1)) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         sck_q   <= 1'b0;
         dout_q  <= 1'b0;
         csld_q  <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         sck_q   <= sck_d;
         dout_q  <= dout_d;
         csld_q  <= csld_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign ACK  = ack_q;
   assign BUSY = busy_q;
   assign SCK  = sck_q;
   assign Dout = dout_q;
   assign CSLD = csld_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Scoreboard bench: an abstract arbitration model queues expected frames and a
// pin-level monitor decodes the serial bus and compares each completed frame.
module tb_dac_update_scheduler;

   localparam int         NCH       = 4;
   localparam int         DW        = 12;
   localparam int         CLKDIV    = 2;
   localparam int         GAP       = 2;
   localparam logic [3:0] CMD       = 4'b0011;
   localparam int         FRAME_CYC = 48 * CLKDIV;

   typedef struct {
      logic [23:0] frame;
      int          ch;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    req;
   logic [NCH*DW-1:0] data;
   logic [NCH-1:0]    ack;
   logic              busy, sck, dout, csld;

   int   tests  = 0;
   int   failed = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   dac_update_scheduler #(
      .NCH(NCH), .DW(DW), .CLKDIV(CLKDIV), .CMD(CMD), .GAP(GAP)
   ) dut (
      .CLK(clk), .RSTn(rst_n), .REQ(req), .DATA(data),
      .ACK(ack), .BUSY(busy), .SCK(sck), .Dout(dout), .CSLD(csld)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a grant occupies the bus for a whole frame plus the gap,
   // after which the next grant goes to the first requester from the pointer.
   int          m_ptr = 0;
   int          m_busy = 0;
   int          m_g;
   logic [15:0] m_code;
   exp_t        m_e;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ptr  = 0;
         m_busy = 0;
         sb_q.delete();
      end else if (m_busy > 0) begin
         m_busy--;
      end else if (req != '0) begin
         m_g = -1;
         for (int i = 0; i < NCH; i++)
            if (m_g < 0 && req[(m_ptr + i) % NCH]) m_g = (m_ptr + i) % NCH;
         m_code     = 16'(data[m_g*DW +: DW]);
         m_e.ch     = m_g;
         m_e.frame  = (24'(CMD) << 20) | (24'(m_g) << 16) | (24'(m_code) << (16 - DW));
         sb_q.push_back(m_e);
         m_ptr  = (m_g + 1) % NCH;
         m_busy = FRAME_CYC + GAP;
      end
   end

   // Monitor: decode bits on SCK rises while CSLD is low, compare on CSLD rise.
   logic        prev_sck = 1'b0, prev_csld = 1'b1, prev_dout = 1'b0;
   logic [23:0] cap = '0, last_word = '0;
   int          nbits = 0, low_cyc = 0, gap_cnt = 0;
   bit          gap_wait = 1'b0, dout_bad = 1'b0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         nbits = 0; low_cyc = 0; gap_wait = 1'b0;
         prev_sck = 1'b0; prev_csld = 1'b1; prev_dout = 1'b0;
      end else begin
         if (gap_wait) begin
            gap_cnt++;
            if (!busy || gap_cnt > GAP + 2) begin
               check_output("busy_gap_len", gap_cnt, GAP);
               gap_wait = 1'b0;
            end
         end
         if (prev_csld && !csld) begin
            check_output("busy_at_start", busy, 1);
            low_cyc = 0; nbits = 0; cap = '0; dout_bad = 1'b0;
         end else if (!prev_csld && !csld && dout != prev_dout && !(prev_sck && !sck)) begin
            dout_bad = 1'b1;
         end
         if (!csld) begin
            low_cyc++;
            if (!prev_sck && sck) begin
               cap = {cap[22:0], dout};
               nbits++;
            end
         end
         if (!prev_csld && csld) begin
            check_output("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check_output("ack_chan", ack, 32'(1) << mon_e.ch);
               check_output("frame_word", cap, mon_e.frame);
            end
            check_output("bit_count", nbits, 24);
            check_output("csld_low_cycles", low_cyc, FRAME_CYC);
            check_output("dout_only_on_fall", dout_bad, 0);
            check_output("idle_pins", {sck, dout}, 2'b00);
            last_word = cap;
            gap_wait  = 1'b1;
            gap_cnt   = 0;
         end else if (ack != '0) begin
            check_output("stray_ack", ack, 0);
         end
         prev_sck  = sck;
         prev_csld = csld;
         prev_dout = dout;
      end
   end

   task automatic wait_ack(input int ch, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (ack[ch]) seen = 1'b1;
      end
      check_output($sformatf("ack_seen_ch%0d", ch), seen, 1);
   endtask

   task automatic wait_any_ack(output int ch, input int budget);
      ch = -1;
      for (int i = 0; i < budget && ch < 0; i++) begin
         @(negedge clk);
         for (int j = NCH - 1; j >= 0; j--) if (ack[j]) ch = j;
      end
   endtask

   task automatic wait_level(input string name, input bit want_busy, input int budget);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         hit = want_busy ? !csld : !busy;
      end
      check_output(name, hit, 1);
   endtask

   task automatic pulse_reset(input logic [NCH-1:0] hold_req);
      @(negedge clk); #2;
      rst_n = 1'b0;
      req   = hold_req;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) begin
            if (ack[i]) req[i] = ($urandom_range(0, 3) == 0);
            else if (!req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b1;
            if ($urandom_range(0, 7) == 0) data[i*DW +: DW] = DW'($urandom);
         end
      end
   endtask

   int got;

   initial begin
      rst_n = 1'b1; req = '0; data = '0;
      #1 rst_n = 1'b0;
      #1;
      check_output("rst_sck", sck, 0);
      check_output("rst_dout", dout, 0);
      check_output("rst_csld", csld, 1);
      check_output("rst_ack", ack, 0);
      check_output("rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Single ch2 frame with a known word.
      @(negedge clk);
      data[2*DW +: DW] = 12'hABC;
      req[2] = 1'b1;
      wait_ack(2, FRAME_CYC + 20);
      req[2] = 1'b0;
      wait_level("idle_after_ch2", 1'b0, 20);
      check_output("ch2_word", last_word, 24'h32ABC0);

      // All four requesting from reset: served in order 0..3.
      for (int i = 0; i < NCH; i++) data[i*DW +: DW] = DW'($urandom);
      pulse_reset('1);
      for (int k = 0; k < NCH; k++) begin
         wait_any_ack(got, FRAME_CYC + 20);
         check_output("rr_order_all", got, k);
         if (got >= 0) req[got] = 1'b0;
      end
      wait_level("idle_after_all", 1'b0, 20);

      // Two channels held: strict alternation.
      req = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         wait_any_ack(got, 2 * FRAME_CYC + 20);
         check_output("rr_alternate", got, (k % 2 == 0) ? 1 : 3);
      end
      req = '0;
      wait_level("idle_after_alt", 1'b0, FRAME_CYC + 20);

      // Reset during bit 10 of a ch0 frame, then a full resend.
      @(negedge clk);
      data[0 +: DW] = DW'($urandom);
      req[0] = 1'b1;
      wait_level("ch0_start", 1'b1, 20);
      repeat (2 * CLKDIV * (23 - 10) + CLKDIV) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("abort_sck", sck, 0);
      check_output("abort_csld", csld, 1);
      check_output("abort_dout", dout, 0);
      check_output("abort_ack", ack, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_ack(0, FRAME_CYC + 20);
      req[0] = 1'b0;
      wait_level("idle_after_abort", 1'b0, 20);

      // DATA and REQ change after grant must not disturb the frame.
      @(negedge clk);
      data[1*DW +: DW] = 12'h123;
      req[1] = 1'b1;
      wait_level("ch1_start", 1'b1, 20);
      repeat (2 * CLKDIV * (23 - 5) + 1) @(negedge clk);
      data[1*DW +: DW] = 12'hFFF;
      req[1] = 1'b0;
      wait_ack(1, FRAME_CYC);
      wait_level("idle_after_ch1", 1'b0, 20);
      check_output("ch1_word", last_word, 24'h311230);

      apply_stimulus(3000);
      req = '0;
      for (int i = 0; i < FRAME_CYC + 40 && (sb_q.size() != 0 || busy); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_output("drain_sb", sb_q.size(), 0);
      check_output("drain_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
